// File: rtl/la_settings_controller.sv
// Front-panel settings controller: button synchronise/debounce/auto-repeat,
// timebase preset, channel select and per-channel trigger kinds.
module la_settings_controller #(
  parameter int unsigned N_CHANNELS      = 16,
  parameter int unsigned N_PRESETS       = 32,
  parameter int unsigned PRESET_W        = 29,
  parameter int unsigned BASE_CLK_HZ     = 400000000,
  parameter int unsigned PRESCALER_TABLE [N_PRESETS] = '{
    1, 2, 4, 8, 16, 20, 32, 40, 80, 160, 200, 400, 800, 1600, 2000, 4000,
    8000, 16000, 20000, 40000, 80000, 160000, 200000, 400000, 800000,
    1600000, 2000000, 4000000, 8000000, 16000000, 20000000, 40000000},
  parameter int unsigned RESET_PRESET    = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 200000000,
  parameter int unsigned REPEAT_PERIOD   = 40000000,
  parameter int unsigned CHAN_WRAP       = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                faster,
  input  logic                                slower,
  input  logic                                chan_next,
  input  logic                                chan_prev,
  input  logic                                trig_toggle,
  input  logic                                trig_clear,
  input  logic                                lock,
  output logic [PRESET_W-1:0]                 PRESCALING_FACTOR,
  output logic [PRESET_W-1:0]                 SAMPLING_FREQUENCY,
  output logic [N_CHANNELS-1:0][1:0]          TRIGGER_KIND,
  output logic [$clog2(N_CHANNELS)-1:0]       CURRENT_CHANNEL,
  output logic [$clog2(N_PRESETS)-1:0]        PRESET_INDEX,
  output logic                                SETTINGS_CHANGED
);

  localparam int unsigned CH_W    = $clog2(N_CHANNELS);
  localparam int unsigned PS_W    = $clog2(N_PRESETS);
  localparam int unsigned N_BTN   = 6;
  localparam int unsigned N_RPT   = 4;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  // Button bit positions; the four navigation buttons occupy the low bits.
  localparam int unsigned B_FASTER = 0;
  localparam int unsigned B_SLOWER = 1;
  localparam int unsigned B_NEXT   = 2;
  localparam int unsigned B_PREV   = 3;
  localparam int unsigned B_TOGGLE = 4;
  localparam int unsigned B_CLEAR  = 5;

  // Elaboration-time preset tables
  logic [PRESET_W-1:0] presc_tbl [N_PRESETS];
  logic [PRESET_W-1:0] freq_tbl  [N_PRESETS];

  for (genvar g = 0; g < N_PRESETS; g++) begin : g_tbl
    assign presc_tbl[g] = PRESET_W'(PRESCALER_TABLE[g]);
    assign freq_tbl[g]  = PRESET_W'(BASE_CLK_HZ / PRESCALER_TABLE[g]);
  end

  // Button front-end state
  logic [N_BTN-1:0]            sync1_q, sync2_q;
  logic [N_BTN-1:0]            level_q, level_d;
  logic [N_BTN-1:0]            prev_q;
  logic [N_BTN-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [N_RPT-1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [N_RPT-1:0]            rpt_first_q, rpt_first_d;
  logic [N_RPT-1:0]            rpt_fire_c;
  logic [N_BTN-1:0]            press_c;

  // Settings state
  logic [PS_W-1:0]            preset_q, preset_d;
  logic [CH_W-1:0]            chan_q, chan_d;
  logic [N_CHANNELS-1:0][1:0] trig_q, trig_d;
  logic [PRESET_W-1:0]        presc_q, freq_q;
  logic                       changed_q, changed_d;

  logic faster_c, slower_c, next_c, prev_c, toggle_c, clear_c;

  // Debounce: level follows the synchronised input only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d[i]  = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign press_c = level_q & ~prev_q;

  // Auto-repeat: count cycles since the press (or last repeat) while held.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire_c  = '0;
    for (int i = 0; i < N_RPT; i++) begin
      if (!level_q[i] || (REPEAT_DELAY == 0)) begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b0;
      end else if (press_c[i]) begin
        rpt_cnt_d[i]   = RPT_W'(1);
        rpt_first_d[i] = 1'b0;
      end else if (!rpt_first_q[i] && (rpt_cnt_q[i] == RPT_W'(REPEAT_DELAY))) begin
        rpt_fire_c[i]  = 1'b1;
        rpt_cnt_d[i]   = RPT_W'(1);
        rpt_first_d[i] = 1'b1;
      end else if (rpt_first_q[i] && (rpt_cnt_q[i] == RPT_W'(REPEAT_PERIOD))) begin
        rpt_fire_c[i]  = 1'b1;
        rpt_cnt_d[i]   = RPT_W'(1);
      end else begin
        rpt_cnt_d[i]   = rpt_cnt_q[i] + RPT_W'(1);
      end
    end
  end

  // Event qualification; lock discards timebase and trigger events only.
  assign faster_c = (press_c[B_FASTER] | rpt_fire_c[B_FASTER]) & ~lock;
  assign slower_c = (press_c[B_SLOWER] | rpt_fire_c[B_SLOWER]) & ~lock;
  assign next_c   =  press_c[B_NEXT]   | rpt_fire_c[B_NEXT];
  assign prev_c   =  press_c[B_PREV]   | rpt_fire_c[B_PREV];
  assign toggle_c =  press_c[B_TOGGLE] & ~lock;
  assign clear_c  =  press_c[B_CLEAR]  & ~lock;

  // Next settings; toggle uses the channel selected before any move.
  always_comb begin
    preset_d  = preset_q;
    chan_d    = chan_q;
    trig_d    = trig_q;
    changed_d = 1'b0;

    if (faster_c) begin
      if (preset_q != PS_W'(N_PRESETS - 1)) preset_d = preset_q + PS_W'(1);
    end else if (slower_c) begin
      if (preset_q != '0) preset_d = preset_q - PS_W'(1);
    end

    if (next_c) begin
      if (chan_q != CH_W'(N_CHANNELS - 1)) chan_d = chan_q + CH_W'(1);
      else if (CHAN_WRAP != 0)             chan_d = '0;
    end else if (prev_c) begin
      if (chan_q != '0)        chan_d = chan_q - CH_W'(1);
      else if (CHAN_WRAP != 0) chan_d = CH_W'(N_CHANNELS - 1);
    end

    if (clear_c) begin
      trig_d = '0;
    end else if (toggle_c) begin
      trig_d[chan_q] = trig_q[chan_q] + 2'd1;
    end

    changed_d = (preset_d != preset_q) || (trig_d != trig_q);
  end

  // Button front-end registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      prev_q      <= '0;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      rpt_first_q <= '0;
    end else begin
      sync1_q     <= {trig_clear, trig_toggle, chan_prev, chan_next, slower, faster};
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      prev_q      <= level_q;
      db_cnt_q    <= db_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  // Settings registers; table outputs load on the same edge as the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      preset_q  <= PS_W'(RESET_PRESET);
      presc_q   <= PRESET_W'(PRESCALER_TABLE[RESET_PRESET]);
      freq_q    <= PRESET_W'(BASE_CLK_HZ / PRESCALER_TABLE[RESET_PRESET]);
      chan_q    <= '0;
      trig_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      preset_q  <= preset_d;
      presc_q   <= presc_tbl[preset_d];
      freq_q    <= freq_tbl[preset_d];
      chan_q    <= chan_d;
      trig_q    <= trig_d;
      changed_q <= changed_d;
    end
  end

  assign PRESCALING_FACTOR  = presc_q;
  assign SAMPLING_FREQUENCY = freq_q;
  assign TRIGGER_KIND       = trig_q;
  assign CURRENT_CHANNEL    = chan_q;
  assign PRESET_INDEX       = preset_q;
  assign SETTINGS_CHANGED   = changed_q;

endmodule

// File: tb/tb_la_settings_controller.sv
// Directed bench for la_settings_controller (debounce 4, repeat 20/5, wrap on).
module tb_la_settings_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        faster = 1'b0, slower = 1'b0, chan_next = 1'b0, chan_prev = 1'b0;
  logic        trig_toggle = 1'b0, trig_clear = 1'b0, lock = 1'b0;
  logic [28:0] presc, freq;
  logic [15:0][1:0] trig;
  logic [3:0]  chan;
  logic [4:0]  pidx;
  logic        changed;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned strobe_total = 0;

  int unsigned presc_ref [32] = '{
    1, 2, 4, 8, 16, 20, 32, 40, 80, 160, 200, 400, 800, 1600, 2000, 4000,
    8000, 16000, 20000, 40000, 80000, 160000, 200000, 400000, 800000,
    1600000, 2000000, 4000000, 8000000, 16000000, 20000000, 40000000};

  typedef struct {
    int unsigned btn;      // 0 faster,1 slower,2 next,3 prev,4 toggle,5 clear
    bit          lk;
    int unsigned idx;
    int unsigned ch;
    logic [31:0] trig;
    int unsigned strobes;
  } vec_t;

  vec_t vecs [15];

  la_settings_controller #(
    .N_CHANNELS(16), .N_PRESETS(32), .PRESET_W(29), .BASE_CLK_HZ(400000000),
    .RESET_PRESET(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5), .CHAN_WRAP(1)
  ) dut (
    .clk(clk), .rst(rst),
    .faster(faster), .slower(slower), .chan_next(chan_next), .chan_prev(chan_prev),
    .trig_toggle(trig_toggle), .trig_clear(trig_clear), .lock(lock),
    .PRESCALING_FACTOR(presc), .SAMPLING_FREQUENCY(freq), .TRIGGER_KIND(trig),
    .CURRENT_CHANNEL(chan), .PRESET_INDEX(pidx), .SETTINGS_CHANGED(changed)
  );

  always #5 clk = ~clk;

  // Count strobe pulses mid-cycle
  always @(negedge clk) if (changed === 1'b1) strobe_total <= strobe_total + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    else n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_btn(input int unsigned b, input logic v);
    case (b)
      0: faster      = v;
      1: slower      = v;
      2: chan_next   = v;
      3: chan_prev   = v;
      4: trig_toggle = v;
      default: trig_clear = v;
    endcase
  endtask

  task automatic check_preset(input string nm, input int unsigned i);
    check({nm, ".idx"},   64'(pidx),  64'(i));
    check({nm, ".presc"}, 64'(presc), 64'(presc_ref[i]));
    check({nm, ".freq"},  64'(freq),  64'(400000000 / presc_ref[i]));
  endtask

  // Clean press: 10 cycles raw high, then 12 idle cycles.
  task automatic run_vectors(input int lo, input int hi);
    for (int v = lo; v < hi; v++) begin
      int unsigned s0;
      string nm;
      nm = $sformatf("vec%0d", v);
      s0 = strobe_total;
      lock = vecs[v].lk;
      set_btn(vecs[v].btn, 1'b1);
      step(10);
      set_btn(vecs[v].btn, 1'b0);
      step(12);
      lock = 1'b0;
      check_preset(nm, vecs[v].idx);
      check({nm, ".chan"},    64'(chan), 64'(vecs[v].ch));
      check({nm, ".trig"},    64'(trig), 64'(vecs[v].trig));
      check({nm, ".strobes"}, 64'(strobe_total - s0), 64'(vecs[v].strobes));
    end
  endtask

  initial begin
    int unsigned s0;

    //            btn lk idx ch  trig          strobes
    vecs[0]  = '{1, 1'b0, 0,  0, 32'h0000_0000, 1};  // slower 1 -> 0
    vecs[1]  = '{1, 1'b0, 0,  0, 32'h0000_0000, 0};  // slower saturates at 0
    vecs[2]  = '{3, 1'b0, 5, 15, 32'h0000_0000, 0};  // prev wraps 0 -> 15
    vecs[3]  = '{4, 1'b0, 5, 15, 32'h4000_0000, 1};  // ch15 -> rising
    vecs[4]  = '{4, 1'b0, 5, 15, 32'h8000_0000, 1};  // ch15 -> falling
    vecs[5]  = '{4, 1'b0, 5, 15, 32'hC000_0000, 1};  // ch15 -> both
    vecs[6]  = '{2, 1'b0, 5,  0, 32'hC000_0000, 0};  // next wraps 15 -> 0
    vecs[7]  = '{4, 1'b0, 5,  0, 32'hC000_0001, 1};  // ch0 -> rising
    vecs[8]  = '{5, 1'b0, 5,  0, 32'h0000_0000, 1};  // clear all
    vecs[9]  = '{5, 1'b0, 5,  0, 32'h0000_0000, 0};  // clear when already clear
    vecs[10] = '{0, 1'b1, 5,  0, 32'h0000_0000, 0};  // locked faster dropped
    vecs[11] = '{4, 1'b1, 5,  0, 32'h0000_0000, 0};  // locked toggle dropped
    vecs[12] = '{2, 1'b1, 5,  1, 32'h0000_0000, 0};  // nav works under lock
    vecs[13] = '{0, 1'b0, 6,  1, 32'h0000_0000, 1};  // no queued event
    vecs[14] = '{0, 1'b0, 7,  1, 32'h0000_0000, 1};

    // Reset state
    step(3);
    rst = 1'b0;
    check_preset("reset", 0);
    check("reset.chan",    64'(chan),    64'd0);
    check("reset.trig",    64'(trig),    64'd0);
    check("reset.changed", 64'(changed), 64'd0);
    step(5);

    // Clean faster press: visible exactly 7 cycles after the raw edge
    faster = 1'b1;
    step(6);
    check("press.idx_at6", 64'(pidx),    64'd0);
    check("press.chg_at6", 64'(changed), 64'd0);
    step(1);
    check_preset("press.at7", 1);
    check("press.chg_at7", 64'(changed), 64'd1);
    step(1);
    check("press.chg_at8", 64'(changed), 64'd0);
    faster = 1'b0;
    step(20);

    // Bouncing input never settles long enough
    s0 = strobe_total;
    for (int k = 0; k < 5; k++) begin
      faster = 1'b1; step(2);
      faster = 1'b0; step(2);
    end
    step(12);
    check("bounce.idx",     64'(pidx), 64'd1);
    check("bounce.strobes", 64'(strobe_total - s0), 64'd0);

    run_vectors(0, 2);

    // Held faster: events at press +0, +20, +25, +30, +35
    s0 = strobe_total;
    faster = 1'b1;
    step(26);
    check("hold.idx_at26", 64'(pidx), 64'd1);
    step(1);
    check("hold.idx_at27", 64'(pidx), 64'd2);
    step(11);
    faster = 1'b0;
    step(20);
    check_preset("hold.final", 5);
    check("hold.strobes", 64'(strobe_total - s0), 64'd5);

    run_vectors(2, 15);

    // Reset while faster is mid-debounce at index 7
    faster = 1'b1;
    step(3);
    rst = 1'b1;
    step(2);
    check_preset("rstmid", 0);
    check("rstmid.chan",    64'(chan),    64'd0);
    check("rstmid.changed", 64'(changed), 64'd0);
    rst = 1'b0;
    step(6);
    check("rstmid.idx_at6", 64'(pidx),    64'd0);
    check("rstmid.chg_at6", 64'(changed), 64'd0);
    step(1);
    check("rstmid.idx_at7", 64'(pidx),    64'd1);
    check("rstmid.chg_at7", 64'(changed), 64'd1);
    faster = 1'b0;
    step(15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
